// File: rtl/sram_word_ctrl_if.sv
// Bus bundle between a 32-bit CPU memory port, the word controller and a byte-wide SRAM macro.
// The controller takes the slave view; the CPU/SRAM environment takes the master view.
interface sram_word_ctrl_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        sram_csb0;
  logic        sram_web0;
  logic [9:0]  sram_addr0;
  logic [7:0]  sram_din0;
  logic [7:0]  sram_dout0;

  modport master (
    output mem_valid,
    output mem_instr,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    output sram_dout0,
    input  mem_rdata,
    input  mem_ready,
    input  sram_csb0,
    input  sram_web0,
    input  sram_addr0,
    input  sram_din0
  );

  modport slave (
    input  mem_valid,
    input  mem_instr,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    input  sram_dout0,
    output mem_rdata,
    output mem_ready,
    output sram_csb0,
    output sram_web0,
    output sram_addr0,
    output sram_din0
  );
endinterface

// File: rtl/sram_word_ctrl.sv
// Serializes 32-bit CPU loads/stores into four byte accesses on a 1 KiB single-port SRAM.
// Fixed latency: read ready 6 cycles after accept, write 5, out-of-window 1.
module sram_word_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  sram_word_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRdWait,
    StWr,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  word_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        pend_q;
  logic [1:0]  pend_lane_q;

  logic        accept;
  logic        in_range;

  logic        csb;
  logic        web;
  logic [9:0]  addr;
  logic [7:0]  din;

  assign accept   = (state_q == StIdle) && bus.mem_valid;
  assign in_range = (bus.mem_addr[31:10] == BASE_ADDR[31:10]);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    unique case (state_q)
      StIdle: begin
        lane_d = 2'd0;
        if (bus.mem_valid) begin
          if (!in_range) begin
            state_d = StDone;
          end else if (bus.mem_wstrb == 4'b0000) begin
            state_d = StRd;
          end else begin
            state_d = StWr;
          end
        end
      end
      StRd: begin
        lane_d = lane_q + 2'd1;
        if (lane_q == 2'd3) begin
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        state_d = StDone;
      end
      StWr: begin
        lane_d = lane_q + 2'd1;
        if (lane_q == 2'd3) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        lane_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      lane_q      <= 2'd0;
      ready_q     <= 1'b0;
      rdata_q     <= 32'h0;
      pend_q      <= 1'b0;
      pend_lane_q <= 2'd0;
      word_q      <= 8'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      ready_q     <= (state_d == StDone);
      // The SRAM returns a byte one cycle after issue; remember which lane it belongs to.
      pend_q      <= (state_q == StRd);
      pend_lane_q <= lane_q;
      if (accept) begin
        word_q  <= bus.mem_addr[9:2];
        wdata_q <= bus.mem_wdata;
        wstrb_q <= bus.mem_wstrb;
        if (!in_range) begin
          rdata_q <= 32'h0;
        end
      end
      if (pend_q) begin
        rdata_q[{pend_lane_q, 3'b000} +: 8] <= bus.sram_dout0;
      end
    end
  end

  // SRAM pins idle high/zero outside the byte-access states
  always_comb begin
    csb  = 1'b1;
    web  = 1'b1;
    addr = 10'h0;
    din  = 8'h0;
    unique case (state_q)
      StRd: begin
        csb  = 1'b0;
        addr = {word_q, lane_q};
      end
      StWr: begin
        // Masked lanes still take their cycle so write latency stays fixed.
        csb  = ~wstrb_q[lane_q];
        web  = 1'b0;
        addr = {word_q, lane_q};
        din  = wdata_q[{lane_q, 3'b000} +: 8];
      end
      default: begin
        csb = 1'b1;
      end
    endcase
    if (rst) begin
      csb = 1'b1;
    end
  end

  assign bus.mem_rdata  = rdata_q;
  assign bus.mem_ready  = ready_q;
  assign bus.sram_csb0  = csb;
  assign bus.sram_web0  = web;
  assign bus.sram_addr0 = addr;
  assign bus.sram_din0  = din;

  logic unused_bits;
  assign unused_bits = ^{bus.mem_instr, bus.mem_addr[1:0]};

`ifndef SYNTHESIS
  ready_single_pulse: assert property (@(posedge clk) disable iff (rst) ready_q |=> !ready_q);
  idle_no_access: assert property (@(posedge clk) disable iff (rst)
    (state_q != StRd && state_q != StWr) |-> csb);
`endif

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Directed bench for sram_word_ctrl with a behavioural byte SRAM and an access log.
module tb_sram_word_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [9:0] addr;
    logic       we;
    logic [7:0] din;
  } acc_t;

  logic clk;
  logic rst;
  logic sram_clr;
  int   checks;
  int   errors;

  logic [7:0] sram [1024];
  acc_t       acc_q [$];
  vec_t       vecs [11];

  sram_word_ctrl_if bus ();

  sram_word_ctrl #(
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: synchronous write, registered read data.
  always @(posedge clk) begin
    if (sram_clr) begin
      for (int i = 0; i < 1024; i++) sram[i] <= 8'h00;
      bus.sram_dout0 <= 8'h00;
    end else if (!bus.sram_csb0) begin
      if (!bus.sram_web0) sram[bus.sram_addr0] <= bus.sram_din0;
      else bus.sram_dout0 <= sram[bus.sram_addr0];
    end
  end

  always @(posedge clk) begin
    if (!bus.sram_csb0) acc_q.push_back('{addr: bus.sram_addr0, we: ~bus.sram_web0,
                                          din: bus.sram_din0});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          n;
    int          base;
    int          k_exp;
    logic        wr;
    logic [9:0]  ea;
    base = acc_q.size();
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_instr = (v.wstrb == 4'b0000);
    bus.mem_addr  = v.addr;
    bus.mem_wdata = v.wdata;
    bus.mem_wstrb = v.wstrb;
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0000;
    n = 1;
    while (!bus.mem_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("vec%0d_latency", idx), n, v.exp_lat);
    chk($sformatf("vec%0d_rdata", idx), bus.mem_rdata, v.exp_rdata);
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d_ready_pulse", idx), {31'h0, bus.mem_ready}, 32'h0);
    // Expected SRAM traffic: every lane for reads, strobed lanes for writes, none out of window.
    wr    = (v.wstrb != 4'b0000);
    k_exp = 0;
    if (v.addr[31:10] == 22'h0) begin
      for (int k = 0; k < 4; k++) begin
        if (!wr || v.wstrb[k]) begin
          ea = {v.addr[9:2], 2'(k)};
          if (base + k_exp < acc_q.size()) begin
            chk($sformatf("vec%0d_acc%0d_addr", idx, k_exp), acc_q[base + k_exp].addr, ea);
            chk($sformatf("vec%0d_acc%0d_we", idx, k_exp), acc_q[base + k_exp].we, wr);
            if (wr) chk($sformatf("vec%0d_acc%0d_din", idx, k_exp), acc_q[base + k_exp].din,
                        v.wdata[8*k +: 8]);
          end
          k_exp++;
        end
      end
    end
    chk($sformatf("vec%0d_acc_count", idx), acc_q.size() - base, k_exp);
  endtask

  initial begin
    int n;
    int n1;
    int base;
    int seen;
    checks = 0;
    errors = 0;

    vecs[0]  = '{32'h0000_0010, 32'hA1B2_C3D4, 4'hF,    32'h0000_0000, 5};
    vecs[1]  = '{32'h0000_0010, 32'h0000_0000, 4'h0,    32'hA1B2_C3D4, 6};
    vecs[2]  = '{32'h0000_0020, 32'h0000_0000, 4'hF,    32'hA1B2_C3D4, 5};
    vecs[3]  = '{32'h0000_0020, 32'hFFFF_FFFF, 4'b0101, 32'hA1B2_C3D4, 5};
    vecs[4]  = '{32'h0000_0020, 32'h0000_0000, 4'h0,    32'h00FF_00FF, 6};
    vecs[5]  = '{32'h0000_0400, 32'h0000_0000, 4'h0,    32'h0000_0000, 1};
    vecs[6]  = '{32'h0000_03FC, 32'h1234_5678, 4'b1010, 32'h0000_0000, 5};
    vecs[7]  = '{32'h0000_03FC, 32'h0000_0000, 4'h0,    32'h1200_5600, 6};
    vecs[8]  = '{32'h0000_0000, 32'hCAFE_BABE, 4'hF,    32'h1200_5600, 5};
    vecs[9]  = '{32'hFFFF_0000, 32'h5555_5555, 4'hF,    32'h0000_0000, 1};
    vecs[10] = '{32'h0000_0000, 32'h0000_0000, 4'h0,    32'hCAFE_BABE, 6};

    rst           = 1'b1;
    sram_clr      = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_instr = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'h0, bus.mem_ready}, 32'h0);
    chk("reset_rdata", bus.mem_rdata, 32'h0);
    chk("reset_csb", {31'h0, bus.sram_csb0}, 32'h1);
    chk("reset_web", {31'h0, bus.sram_web0}, 32'h1);
    chk("reset_addr", {22'h0, bus.sram_addr0}, 32'h0);
    chk("reset_din", {24'h0, bus.sram_din0}, 32'h0);
    @(negedge clk);
    rst      = 1'b0;
    sram_clr = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    chk("sram_0x10", {24'h0, sram[10'h010]}, 32'hD4);
    chk("sram_0x11", {24'h0, sram[10'h011]}, 32'hC3);
    chk("sram_0x12", {24'h0, sram[10'h012]}, 32'hB2);
    chk("sram_0x13", {24'h0, sram[10'h013]}, 32'hA1);

    // Reset during the lane-2 read cycle drops the transaction.
    base = acc_q.size();
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0000_0010;
    bus.mem_wstrb = 4'h0;
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst_mid_lane2_addr", {22'h0, bus.sram_addr0}, 32'h012);
    chk("rst_mid_lane2_csb_pre", {31'h0, bus.sram_csb0}, 32'h0);
    rst = 1'b1;
    #1;
    chk("rst_mid_csb_comb", {31'h0, bus.sram_csb0}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_ready", {31'h0, bus.mem_ready}, 32'h0);
    chk("rst_mid_rdata", bus.mem_rdata, 32'h0);
    chk("rst_mid_idle_csb", {31'h0, bus.sram_csb0}, 32'h1);
    chk("rst_mid_idle_addr", {22'h0, bus.sram_addr0}, 32'h0);
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.mem_ready) seen++;
    end
    chk("rst_mid_no_ready", seen, 0);
    chk("rst_mid_acc_count", acc_q.size() - base, 2);
    run_vec(11, '{32'h0000_03FC, 32'h0, 4'h0, 32'h1200_5600, 6});

    // Back-to-back reads with mem_valid held through DONE.
    base = acc_q.size();
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0000_03FC;
    bus.mem_wstrb = 4'h0;
    @(posedge clk);
    #1;
    bus.mem_addr = 32'h0000_0000;
    n = 1;
    while (!bus.mem_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    n1 = n;
    chk("b2b_first_latency", n1, 6);
    chk("b2b_first_rdata", bus.mem_rdata, 32'h1200_5600);
    @(posedge clk);
    #1;
    n++;
    while (!bus.mem_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.mem_valid = 1'b0;
    // DONE is never an accept cycle, so the next accept lands one cycle later: 6 + 1.
    chk("b2b_ready_gap", n - n1, 7);
    chk("b2b_second_rdata", bus.mem_rdata, 32'hCAFE_BABE);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_acc_count", acc_q.size() - base, 8);
    for (int j = 0; j < 8; j++) begin
      if (base + j < acc_q.size()) begin
        chk($sformatf("b2b_addr%0d", j), {22'h0, acc_q[base + j].addr},
            (j < 4) ? 32'h3FC + 32'(j) : 32'(j - 4));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_word_ctrl.md
SRAM_WORD_CTRL -- requirements
Module: sram_word_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000; base of the 1 KiB SRAM window, bits [9:0] ignored.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_valid  in  1  CPU request valid.
- mem_instr  in  1  instruction fetch flag; no functional effect.
- mem_addr  in  32  byte address; word-aligned.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write strobes; 4'b0000 means read.
- mem_rdata  out  32  read data, registered.
- mem_ready  out  1  one-cycle completion pulse, registered.
- sram_csb0  out  1  SRAM chip select, active-low.
- sram_web0  out  1  SRAM write enable, active-low.
- sram_addr0  out  10  SRAM byte address.
- sram_din0  out  8  SRAM write byte.
- sram_dout0  in  8  SRAM read byte; valid the cycle after its read issue.

Function
REQ-003 SHALL serialize each 32-bit CPU access into four 8-bit SRAM accesses, lanes 0..3; lane k maps to mem_rdata/mem_wdata bits [8k+7:8k].
REQ-004 SHALL use states IDLE, RD, RD_WAIT, WR, DONE, plus a 2-bit lane counter.
REQ-005 IDLE SHALL accept a request when mem_valid=1 at a clock edge, and latch mem_addr[9:2], mem_wdata and mem_wstrb at that edge.
REQ-006 Request SHALL be in range iff mem_addr[31:10]==BASE_ADDR[31:10].
REQ-007 In-range, wstrb==0: IDLE->RD; wstrb!=0: IDLE->WR; out of range: IDLE->DONE with mem_rdata loaded to 32'h0 and no SRAM access.
REQ-008 RD, lane k SHALL drive sram_csb0=0, sram_web0=1 and sram_addr0={word,k}; lane increments each cycle; after lane 3, RD->RD_WAIT.
REQ-009 The byte for lane k SHALL be captured from sram_dout0 into mem_rdata[8k+7:8k] at the edge ending the cycle after lane k's issue; RD_WAIT captures lane 3, then RD_WAIT->DONE.
REQ-010 WR, lane k SHALL drive sram_addr0={word,k}, sram_din0=wdata byte k and sram_web0=0, with sram_csb0=0 only if wstrb[k]=1; after lane 3, WR->DONE.
REQ-011 DONE SHALL hold mem_ready=1 for exactly one cycle, then go DONE->IDLE; IDLE never accepts in the DONE cycle.
REQ-012 Latency, first accept edge ending cycle T: read mem_ready in cycle T+6; write in T+5; out-of-range in T+1.
REQ-013 mem_rdata SHALL change only on read captures or an out-of-range load, and hold otherwise, including across writes.
REQ-014 Outside RD/WR, sram_csb0=1, sram_web0=1, sram_addr0=0 and sram_din0=0.
REQ-015 mem_valid deasserting mid-transaction SHALL NOT abort it; the transaction completes with normal timing.
REQ-016 Lanes with wstrb[k]=0 SHALL still consume a cycle, giving fixed latency; wstrb 4'b0000 is never a write.

Reset
REQ-017 rst=1 at an edge SHALL force IDLE, lane=0, mem_ready=0 and mem_rdata=0, in any state.
REQ-018 While rst=1, sram_csb0 SHALL be 1 combinationally, so no SRAM access occurs in the reset cycle.
REQ-019 A transaction interrupted by reset SHALL be dropped with no mem_ready; partial writes already issued remain in SRAM.

Verification
REQ-020 Write 32'hA1B2C3D4, wstrb 4'hF at 0x10, then read 0x10 -> SRAM bytes 0x10..0x13 = D4,C3,B2,A1; read mem_rdata=32'hA1B2C3D4; ready at T+5 and T+6.
REQ-021 Write 32'hFFFFFFFF, wstrb 4'b0101 over 0x00000000 at 0x20, then read -> 32'h00FF00FF; sram_csb0 low only in lanes 0 and 2.
REQ-022 Read 0x0000_0400 (BASE_ADDR=0) -> mem_ready at T+1, mem_rdata=0, sram_csb0 stays 1 throughout.
REQ-023 rst=1 in the RD cycle for lane 2 -> next cycle IDLE, mem_ready=0, mem_rdata=0; a following read of word 0x3FC completes normally.
REQ-024 Back-to-back reads of 0x3FC then 0x000 with mem_valid held high through DONE -> two distinct ready pulses at least 7 cycles apart; sram_addr0 sequence 0x3FC..0x3FF then 0x000..0x003, with no wrap error.
